// File: rtl/rd_fwft_stage_if.sv
// rd_fwft_stage_if: groups the two handshakes of the FIFO read-side output stage.
//
// FIFO side: rinc pops the FIFO head. It is only meaningful while rempty is 0.
// rdata is the current FIFO head and is valid whenever rempty is 0.
//
// Stream side: a word transfers on a cycle where dout_valid and dout_ready are
// both 1. While dout_valid is 1 and dout_ready is 0, dout and dout_valid hold
// steady. dout_ready is ignored while dout_valid is 0.
interface rd_fwft_stage_if #(
  parameter int DSIZE = 8
);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [DSIZE-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  // The stage itself.
  modport slave (
    input  rempty,
    input  rdata,
    input  dout_ready,
    output rinc,
    output dout,
    output dout_valid
  );

  // The environment: pointer/memory logic on one side and the consumer on the other.
  modport master (
    output rempty,
    output rdata,
    output dout_ready,
    input  rinc,
    input  dout,
    input  dout_valid
  );
endinterface

// File: rtl/rd_fwft_stage.sv
// rd_fwft_stage: read-side first-word-fall-through output stage of the async FIFO.
// It converts the rempty/rinc pop interface into a valid/ready stream. The stage
// uses a two-entry buffer (head + skid), so rinc never depends on dout_ready.
// The occ output exposes the FSM state (0 = EMPTY, 1 = ONE, 2 = TWO).
// Optional feature macro: RD_FWFT_XFER_CNT_EN adds the 16-bit xfer_cnt beat counter.
module rd_fwft_stage #(
  parameter int DSIZE = 8
) (
  input  logic                 rclk,
  input  logic                 rrst,
  rd_fwft_stage_if.slave       bus,
  output logic [1:0]           occ
`ifdef RD_FWFT_XFER_CNT_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] head_d;
  logic [DSIZE-1:0] skid_q;
  logic [DSIZE-1:0] skid_d;
  logic             push;
  logic             pop;

  // The pop request uses only registered state and the registered empty flag,
  // so there is no combinational path from dout_ready to rinc.
  assign push           = ~rrst & ~bus.rempty & (state_q != ST_TWO);
  assign bus.rinc       = push;
  assign bus.dout_valid = (state_q != ST_EMPTY);
  assign bus.dout       = head_q;
  assign pop            = bus.dout_valid & bus.dout_ready;
  assign occ            = state_q;

  // Next-state and buffer update: head always holds the oldest word.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = bus.rdata;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = bus.rdata;
        end else if (push) begin
          skid_d  = bus.rdata;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // push is blocked in this state, so only a pop can move it
        if (pop) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        // Recover from the illegal encoding by discarding the contents.
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State and data registers; reset discards any buffered words.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef RD_FWFT_XFER_CNT_EN
  // Accepted-beat counter; it wraps naturally at 16 bits.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      xfer_cnt <= 16'd0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rd_fwft_stage.sv
// tb_rd_fwft_stage: directed bench for rd_fwft_stage with a queue-based FIFO
// model upstream and a scoreboard monitor on the output stream.
module tb_rd_fwft_stage;
  localparam int DSIZE = 8;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [1:0] occ;
`ifdef RD_FWFT_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  rd_fwft_stage_if #(.DSIZE(DSIZE)) bus ();

  rd_fwft_stage #(.DSIZE(DSIZE)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .bus      (bus),
    .occ      (occ)
`ifdef RD_FWFT_XFER_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  // clock / reset
  always #5 rclk = ~rclk;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int beats = 0;
  int rinc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver task: a word enters the upstream FIFO and is expected on the stream
  task automatic push_word(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic next_cycle();
    @(posedge rclk);
    #1;
  endtask

  // Upstream FIFO model: pops on rinc and presents a registered empty flag.
  initial begin
    bus.rempty = 1'b1;
    bus.rdata  = '0;
    forever begin
      @(posedge rclk);
      if (bus.rinc && fifo_q.size() > 0) void'(fifo_q.pop_front());
      #2;
      bus.rempty = (fifo_q.size() == 0);
      bus.rdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Scoreboard monitor: compares every accepted beat with the expected queue.
  initial begin
    logic [DSIZE-1:0] exp;
    forever begin
      @(negedge rclk);
      if (bus.rinc) rinc_cnt++;
      if (!rrst && bus.dout_valid && bus.dout_ready) begin
        beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got %0h expected none", bus.dout);
        end else begin
          exp = exp_q.pop_front();
          if (bus.dout !== exp) begin
            errors++;
            $display("FAIL beat_data got %0h expected %0h", bus.dout, exp);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int r0;
    int b0;
    rrst = 1'b1;
    bus.dout_ready = 1'b1;

    // Reset with a non-empty FIFO: rinc must stay low throughout.
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    repeat (3) begin
      @(negedge rclk);
      check("rst_rinc", bus.rinc, 0);
    end
    check("rst_occ", occ, 0);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_dout", bus.dout, 0);

    // Streaming with ready held high.
    next_cycle();
    rrst = 1'b0;
    r0 = rinc_cnt;
    @(negedge rclk);
    check("s_k0_rinc", bus.rinc, 1);
    check("s_k0_valid", bus.dout_valid, 0);
    @(negedge rclk);
    check("s_k1_valid", bus.dout_valid, 1);
    check("s_k1_dout", bus.dout, 8'h11);
    @(negedge rclk);
    check("s_k2_dout", bus.dout, 8'h22);
    @(negedge rclk);
    check("s_k3_dout", bus.dout, 8'h33);
    check("s_k3_rinc", bus.rinc, 0);
    @(negedge rclk);
    #1;
    check("s_rinc_pulses", rinc_cnt - r0, 3);
    check("s_end_occ", occ, 0);
    check("s_end_valid", bus.dout_valid, 0);

    // Backpressure: only two words are absorbed.
    next_cycle();
    bus.dout_ready = 1'b0;
    r0 = rinc_cnt;
    for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
    for (int i = 0; i < 6; i++) begin
      @(negedge rclk);
      if (i >= 1) begin
        check("bp_valid", bus.dout_valid, 1);
        check("bp_dout", bus.dout, 8'hA0);
      end
    end
    #1;
    check("bp_rinc_pulses", rinc_cnt - r0, 2);
    check("bp_occ", occ, 2);
    check("bp_rinc_low", bus.rinc, 0);

    // Release: five back-to-back beats in order.
    next_cycle();
    bus.dout_ready = 1'b1;
    b0 = beats;
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      check("rel_nogap", bus.dout_valid, 1);
    end
    #1;
    check("rel_beats", beats - b0, 5);
    @(negedge rclk);
    check("rel_drained", bus.dout_valid, 0);

    // Reset while two words are buffered.
    next_cycle();
    bus.dout_ready = 1'b0;
    push_word(8'hB0);
    push_word(8'hB1);
    push_word(8'hB2);
    repeat (4) @(negedge rclk);
    check("mr_occ_full", occ, 2);
    check("mr_head", bus.dout, 8'hB0);
    next_cycle();
    rrst = 1'b1;
    // B0 and B1 are discarded; B2 is still in the FIFO.
    exp_q.delete();
    exp_q.push_back(8'hB2);
    @(negedge rclk);
    check("mr_rinc_in_rst", bus.rinc, 0);
    next_cycle();
    rrst = 1'b0;
    bus.dout_ready = 1'b1;
    @(negedge rclk);
    check("mr_occ", occ, 0);
    check("mr_valid", bus.dout_valid, 0);
    check("mr_rinc", bus.rinc, 1);
    @(negedge rclk);
    check("mr_first_valid", bus.dout_valid, 1);
    check("mr_first_dout", bus.dout, 8'hB2);
    repeat (3) @(negedge rclk);

`ifdef RD_FWFT_XFER_CNT_EN
    // Counter wrap: 65537 beats after reset leaves the counter at 1.
    next_cycle();
    rrst = 1'b1;
    next_cycle();
    rrst = 1'b0;
    @(negedge rclk);
    check("cnt_rst", xfer_cnt, 0);
    next_cycle();
    for (int i = 0; i < 65537; i++) push_word(8'(i));
    begin
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.dout_valid) && n < 70000) begin
        @(negedge rclk);
        n++;
      end
      check("cnt_timeout", (n < 70000) ? 1 : 0, 1);
    end
    check("cnt_wrap", xfer_cnt, 16'd1);
`endif

    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
